// File: rtl/cnn_pkg.sv
// Shared helpers for the CNN streaming blocks.
//   conv_out_dim : number of window positions along one axis after padding and stride
//   pix_width    : packed width of one pixel beat (all channels)
//   cnt_width    : counter width able to hold 0..n-1 (never less than 1 bit)
package cnn_pkg;

    function automatic int conv_out_dim(input int in_dim, input int k, input int p, input int s);
        return (in_dim + 2 * p - k) / s + 1;
    endfunction

    function automatic int pix_width(input int data_width, input int channels);
        return data_width * channels;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_line_row.sv
// One line-buffer row: a pDEPTH-deep pixel delay addressed by the scan column.
// The old value at addr is read combinationally and replaced by din on the same
// enabled edge, so dout is the pixel seen exactly one padded row earlier.
//   clk  in   clock
//   en   in   shift enable (one padded position consumed)
//   addr in   current padded column, used as circular write pointer
//   din  in   pixel entering this row
//   dout out  pixel stored one row ago at this column
module conv_line_row #(
    parameter int pDEPTH  = 226,
    parameter int pWIDTH  = 24,
    parameter int pADDR_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic [pADDR_W-1:0] addr,
    input  logic [pWIDTH-1:0] din,
    output logic [pWIDTH-1:0] dout
);

    logic [pWIDTH-1:0] mem [pDEPTH];

    assign dout = mem[addr];

    // NOTE: storage arrays take no reset; every entry is rewritten before it can reach
    // an emitted window, and leaving reset off lets the array map onto RAM/SRL cells.
    // NOTE: sequential state is always written with <= so all flops sample together.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/conv_window_stream.sv
// Raster pixel stream (all channels per beat) to KxK convolution windows with zero
// padding and stride, valid/ready on both sides, frames back to back.
//   clk, rst      clock, synchronous active-high reset
//   clear         synchronous frame abort (control state only, like rst)
//   in_valid/in_ready/in_data    pixel input, channel 0 in LSBs
//   out_valid/out_ready/out_data window output, element (r,c) at [(r*K+c)*PIX_W +: PIX_W]
//   out_last      marks the final window of a frame
//   done          one-cycle pulse after the final window is consumed
module conv_window_stream
    import cnn_pkg::*;
#(
    parameter int pDATA_WIDTH   = 8,
    parameter int pIN_CHANNEL   = 3,
    parameter int pINPUT_WIDTH  = 224,
    parameter int pINPUT_HEIGHT = 224,
    parameter int pKERNEL_SIZE  = 3,
    parameter int pPADDING      = 1,
    parameter int pSTRIDE       = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic in_valid,
    input  logic [pDATA_WIDTH*pIN_CHANNEL-1:0] in_data,
    output logic in_ready,
    output logic out_valid,
    output logic [pDATA_WIDTH*pIN_CHANNEL*pKERNEL_SIZE*pKERNEL_SIZE-1:0] out_data,
    input  logic out_ready,
    output logic out_last,
    output logic done
);

    localparam int PIX_W    = pix_width(pDATA_WIDTH, pIN_CHANNEL);
    localparam int K        = pKERNEL_SIZE;
    localparam int P        = pPADDING;
    localparam int S        = pSTRIDE;
    localparam int PW       = pINPUT_WIDTH + 2 * P;
    localparam int PH       = pINPUT_HEIGHT + 2 * P;
    localparam int OW       = conv_out_dim(pINPUT_WIDTH, K, P, S);
    localparam int OH       = conv_out_dim(pINPUT_HEIGHT, K, P, S);
    // Bottom-right corner of the last window; trailing positions beyond it form no window.
    localparam int LAST_ROW = K - 1 + (OH - 1) * S;
    localparam int LAST_COL = K - 1 + (OW - 1) * S;
    localparam int COL_W    = cnt_width(PW);
    localparam int ROW_W    = cnt_width(PH);
    localparam int PH_W     = cnt_width(S);
    localparam int NROWS    = (K > 1) ? K - 1 : 1;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [PH_W-1:0]  col_ph;   // (col-K+1) mod S, held at 0 until col reaches K-1
    logic [PH_W-1:0]  row_ph;   // (row-K+1) mod S, held at 0 until row reaches K-1
    int               row_i;
    int               col_i;

    logic is_pad;
    logic advance;
    logic emit;
    logic row_end;
    logic frame_end;
    logic row_in_win;
    logic col_in_win;
    logic last_pos;

    logic [PIX_W-1:0]     pix_in;
    logic [PIX_W-1:0]     taps   [NROWS];  // taps[j] = pixel j+1 rows above the scan position
    logic [PIX_W-1:0]     col_in [K];      // newest window column, top to bottom
    logic [PIX_W-1:0]     hist   [K][NROWS];
    logic [PIX_W*K*K-1:0] win_next;

    function automatic logic [PH_W-1:0] ph_inc(input logic [PH_W-1:0] ph);
        return (ph == PH_W'(S - 1)) ? '0 : ph + 1'b1;
    endfunction

    assign row_i = int'(row);
    assign col_i = int'(col);

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        is_pad     = (row_i < P) || (row_i >= P + pINPUT_HEIGHT) ||
                     (col_i < P) || (col_i >= P + pINPUT_WIDTH);
        row_end    = (col_i == PW - 1);
        frame_end  = row_end && (row_i == PH - 1);
        row_in_win = (row_i >= K - 1);
        col_in_win = (col_i >= K - 1);
        // Pad positions never wait for input; nothing moves while a window is held.
        advance    = (is_pad || in_valid) && (!out_valid || out_ready) && !rst && !clear;
        in_ready   = advance && !is_pad;
        pix_in     = is_pad ? '0 : in_data;
        emit       = advance && row_in_win && col_in_win && (row_ph == '0) && (col_ph == '0);
        last_pos   = (row_i == LAST_ROW) && (col_i == LAST_COL);
    end

    // Padded-frame scan position and stride phase.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            col    <= '0;
            row    <= '0;
            col_ph <= '0;
            row_ph <= '0;
        end else if (advance) begin
            if (row_end) begin
                col    <= '0;
                col_ph <= '0;
                if (frame_end) begin
                    row    <= '0;
                    row_ph <= '0;
                end else begin
                    row <= row + 1'b1;
                    if (row_in_win) begin
                        row_ph <= ph_inc(row_ph);
                    end
                end
            end else begin
                col <= col + 1'b1;
                if (col_in_win) begin
                    col_ph <= ph_inc(col_ph);
                end
            end
        end
    end

    // Line buffer: K-1 chained rows, each delaying by exactly one padded row.
    generate
        if (K == 1) begin : g_no_line
            assign taps[0] = '0;
        end
        for (genvar j = 0; j < K - 1; j++) begin : g_line
            logic [PIX_W-1:0] row_din;
            if (j == 0) begin : g_first
                assign row_din = pix_in;
            end else begin : g_chain
                assign row_din = taps[j-1];
            end
            conv_line_row #(
                .pDEPTH (PW),
                .pWIDTH (PIX_W),
                .pADDR_W(COL_W)
            ) u_row (
                .clk (clk),
                .en  (advance),
                .addr(col),
                .din (row_din),
                .dout(taps[j])
            );
        end

        // Window row r holds image row (row-(K-1-r)); the bottom row is the live pixel.
        for (genvar r = 0; r < K; r++) begin : g_col_in
            if (r == K - 1) begin : g_live
                assign col_in[r] = pix_in;
            end else begin : g_tap
                assign col_in[r] = taps[K-2-r];
            end
        end

        // Window including the pixel being shifted in this cycle: older columns from hist,
        // newest (rightmost) column from col_in.
        for (genvar r = 0; r < K; r++) begin : g_win_r
            for (genvar c = 0; c < K; c++) begin : g_win_c
                if (c < K - 1) begin : g_old
                    assign win_next[(r*K+c)*PIX_W +: PIX_W] = hist[r][c];
                end else begin : g_new
                    assign win_next[(r*K+c)*PIX_W +: PIX_W] = col_in[r];
                end
            end
        end
    endgenerate

    // Keep the rightmost K-1 columns for the next shift.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    hist[r][c] <= win_next[(r*K+c+1)*PIX_W +: PIX_W];
                end
            end
        end
    end

    // Output handshake. emit implies the register is empty or being consumed now.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= out_valid && out_ready && out_last;
            if (emit) begin
                out_valid <= 1'b1;
                out_last  <= last_pos;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (emit) begin
            out_data <= win_next;
        end
    end

endmodule

// File: tb/tb_conv_window_stream.sv
// Directed bench for conv_window_stream with two instances:
//   d=0 : W=H=4, K=3, P=1, S=2 (4 windows/frame)
//   d=1 : W=H=5, K=3, P=0, S=1 (9 windows/frame)
// Pixel idx of a frame with base b carries ch0=b+idx+1, ch1=ch0+0x80.
module tb_conv_window_stream;

    localparam int PIX = 16;
    localparam int OUT = PIX * 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst       [2];
    logic           clear     [2];
    logic           in_valid  [2];
    logic [PIX-1:0] in_data   [2];
    logic           in_ready  [2];
    logic           out_valid [2];
    logic [OUT-1:0] out_data  [2];
    logic           out_ready [2];
    logic           out_last  [2];
    logic           done      [2];

    conv_window_stream #(
        .pDATA_WIDTH(8), .pIN_CHANNEL(2), .pINPUT_WIDTH(4), .pINPUT_HEIGHT(4),
        .pKERNEL_SIZE(3), .pPADDING(1), .pSTRIDE(2)
    ) dut_a (
        .clk(clk), .rst(rst[0]), .clear(clear[0]), .in_valid(in_valid[0]),
        .in_data(in_data[0]), .in_ready(in_ready[0]), .out_valid(out_valid[0]),
        .out_data(out_data[0]), .out_ready(out_ready[0]), .out_last(out_last[0]),
        .done(done[0])
    );

    conv_window_stream #(
        .pDATA_WIDTH(8), .pIN_CHANNEL(2), .pINPUT_WIDTH(5), .pINPUT_HEIGHT(5),
        .pKERNEL_SIZE(3), .pPADDING(0), .pSTRIDE(1)
    ) dut_b (
        .clk(clk), .rst(rst[1]), .clear(clear[1]), .in_valid(in_valid[1]),
        .in_data(in_data[1]), .in_ready(in_ready[1]), .out_valid(out_valid[1]),
        .out_data(out_data[1]), .out_ready(out_ready[1]), .out_last(out_last[1]),
        .done(done[1])
    );

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    // Stimulus controls and scoreboard state, per instance.
    logic rst_v [2]   = '{1'b1, 1'b1};
    logic clr_v [2]   = '{1'b0, 1'b0};
    logic feed  [2]   = '{1'b0, 1'b0};
    logic rnd   [2]   = '{1'b0, 1'b0};
    logic rdy   [2]   = '{1'b1, 1'b1};
    int   plimit [2]  = '{0, 0};
    int   pcount [2]  = '{0, 0};
    int   pidx   [2]  = '{0, 0};
    int   fbase  [2]  = '{0, 0};
    int   ebase  [2]  = '{0, 0};
    int   widx   [2]  = '{0, 0};
    int   hs_cnt [2]  = '{0, 0};
    int   done_cnt [2] = '{0, 0};
    int   last_hs_cyc [2] = '{-1, -1};
    int   done_cyc [2] = '{-1, -1};
    int   first_acc = -1;
    int   f2_acc    = -1;
    int   drops     = 0;
    logic [OUT-1:0] cap_a [4];
    logic [OUT-1:0] cap_first [2];
    logic [OUT-1:0] held;

    function automatic int npix(input int d);
        return (d == 0) ? 16 : 25;
    endfunction

    function automatic int nwin(input int d);
        return (d == 0) ? 4 : 9;
    endfunction

    function automatic logic [PIX-1:0] pix(input int base, input int idx);
        logic [7:0] v;
        v = 8'(base + idx + 1);
        return {8'(v + 8'h80), v};
    endfunction

    // Reference window straight from padded-frame geometry.
    function automatic logic [OUT-1:0] gold(input int d, input int base, input int wi);
        int w, p, s, pw, ow, r0, c0, pr, pc;
        logic [OUT-1:0] res;
        w  = (d == 0) ? 4 : 5;
        p  = (d == 0) ? 1 : 0;
        s  = (d == 0) ? 2 : 1;
        pw = w + 2 * p;
        ow = (pw - 3) / s + 1;
        r0 = (wi / ow) * s;
        c0 = (wi % ow) * s;
        res = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                pr = r0 + r;
                pc = c0 + c;
                if (pr >= p && pr < p + w && pc >= p && pc < p + w)
                    res[(r*3+c)*PIX +: PIX] = pix(base, (pr - p) * w + (pc - p));
            end
        end
        return res;
    endfunction

    // Hand-written window: ch0 values in reading order, 0 means padding.
    function automatic logic [OUT-1:0] pack9(input int v [9]);
        logic [OUT-1:0] res;
        logic [7:0] b;
        res = '0;
        for (int i = 0; i < 9; i++) begin
            b = 8'(v[i]);
            if (v[i] != 0) res[i*PIX +: PIX] = {8'(b + 8'h80), b};
        end
        return res;
    endfunction

    task automatic check(input string tag, input logic [OUT-1:0] obs, input logic [OUT-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, observe 1 ns later, book handshakes
    // that the next rising edge will perform.
    task automatic cyc();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            rst[d]       = rst_v[d];
            clear[d]     = clr_v[d];
            in_valid[d]  = feed[d] && (pcount[d] < plimit[d]) &&
                           (!rnd[d] || ($urandom_range(0, 1) == 1));
            in_data[d]   = pix(fbase[d], pidx[d]);
            out_ready[d] = rnd[d] ? ($urandom_range(0, 1) == 1) : rdy[d];
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            if (in_valid[d] && in_ready[d]) begin
                if (d == 0 && pcount[0] == 0)  first_acc = cycle;
                if (d == 0 && pcount[0] == 16) f2_acc = cycle;
                pcount[d]++;
                pidx[d]++;
                if (pidx[d] == npix(d)) begin
                    pidx[d] = 0;
                    fbase[d] += 50;
                end
            end
            if (d == 1 && in_valid[1] && !in_ready[1]) drops++;
            if (out_valid[d] && out_ready[d]) begin
                check($sformatf("win d%0d b%0d w%0d", d, ebase[d], widx[d]),
                      out_data[d], gold(d, ebase[d], widx[d]));
                check($sformatf("last d%0d b%0d w%0d", d, ebase[d], widx[d]),
                      OUT'(out_last[d]), OUT'(widx[d] == nwin(d) - 1));
                if (d == 0 && hs_cnt[0] < 4) cap_a[hs_cnt[0]] = out_data[0];
                if (widx[d] == 0) cap_first[d] = out_data[d];
                hs_cnt[d]++;
                last_hs_cyc[d] = cycle;
                widx[d]++;
                if (widx[d] == nwin(d)) begin
                    widx[d] = 0;
                    ebase[d] += 50;
                end
            end
            if (done[d] === 1'b1) begin
                done_cnt[d]++;
                done_cyc[d] = cycle;
            end
        end
        cycle++;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; clear[d] = 1'b0; in_valid[d] = 1'b0;
            in_data[d] = '0; out_ready[d] = 1'b1;
        end

        // Reset with a pixel offered: nothing may be taken or flagged.
        feed[0] = 1'b1; plimit[0] = 32;
        repeat (3) cyc();
        check("rst in_ready",  OUT'(in_ready[0]),  '0);
        check("rst out_valid", OUT'(out_valid[0]), '0);
        check("rst out_last",  OUT'(out_last[0]),  '0);
        check("rst done",      OUT'(done[0]),      '0);
        check("rst b valid",   OUT'(out_valid[1]), '0);

        // Frame A1: continuous input, out_ready=1.
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
        cycle = 0;
        for (int n = 0; n < 200 && done_cnt[0] < 1; n++) cyc();
        check("a1 first accept cycle", OUT'(first_acc), OUT'(7));
        check("a1 pixels taken", OUT'(pcount[0]), OUT'(16));
        check("a1 windows", OUT'(hs_cnt[0]), OUT'(4));
        check("a1 last window cycle", OUT'(last_hs_cyc[0]), OUT'(29));
        check("a1 done cycle", OUT'(done_cyc[0]), OUT'(30));
        check("a1 window0 hand", cap_a[0], pack9('{0, 0, 0, 0, 1, 2, 0, 5, 6}));
        check("a1 window1 hand", cap_a[1], pack9('{0, 0, 0, 2, 3, 4, 6, 7, 8}));
        check("a1 window3 hand", cap_a[3], pack9('{6, 7, 8, 10, 11, 12, 14, 15, 16}));

        // Frame A2: stall the output after window 1 for 10 cycles.
        for (int n = 0; n < 200 && hs_cnt[0] < 6; n++) cyc();
        rdy[0] = 1'b0;
        cyc();
        for (int n = 0; n < 200 && out_valid[0] !== 1'b1; n++) cyc();
        held = out_data[0];
        for (int n = 0; n < 10; n++) begin
            cyc();
            check($sformatf("stall data %0d", n), out_data[0], held);
            check($sformatf("stall in_ready %0d", n), OUT'(in_ready[0]), '0);
            check($sformatf("stall valid %0d", n), OUT'(out_valid[0]), OUT'(1));
        end
        rdy[0] = 1'b1;
        for (int n = 0; n < 300 && done_cnt[0] < 2; n++) cyc();
        check("a2 next-frame first accept cycle", OUT'(f2_acc), OUT'(43));
        check("a2 pixels taken", OUT'(pcount[0]), OUT'(32));
        check("a2 windows", OUT'(hs_cnt[0]), OUT'(8));
        check("a2 done pulses", OUT'(done_cnt[0]), OUT'(2));

        // Frames A3, A4: random in_valid / out_ready, back to back.
        rnd[0] = 1'b1; plimit[0] = 64;
        for (int n = 0; n < 3000 && done_cnt[0] < 4; n++) cyc();
        rnd[0] = 1'b0;
        check("a34 windows", OUT'(hs_cnt[0]), OUT'(16));
        check("a34 done pulses", OUT'(done_cnt[0]), OUT'(4));
        check("a34 pixels taken", OUT'(pcount[0]), OUT'(64));

        // Frame B1: no padding, in_ready must follow in_valid throughout.
        feed[1] = 1'b1; plimit[1] = 25;
        for (int n = 0; n < 200 && done_cnt[1] < 1; n++) cyc();
        check("b1 in_ready drops", OUT'(drops), '0);
        check("b1 windows", OUT'(hs_cnt[1]), OUT'(9));
        check("b1 pixels taken", OUT'(pcount[1]), OUT'(25));
        check("b1 done after last", OUT'(done_cyc[1] - last_hs_cyc[1]), OUT'(1));

        // Abort after 7 pixels, then a full fresh frame.
        plimit[1] = 32;
        for (int n = 0; n < 200 && pcount[1] < 32; n++) cyc();
        clr_v[1] = 1'b1;
        cyc();
        check("clear in_ready", OUT'(in_ready[1]), '0);
        clr_v[1] = 1'b0;
        pidx[1] = 0; fbase[1] = 200; ebase[1] = 200; widx[1] = 0;
        plimit[1] = 57;
        for (int n = 0; n < 300 && done_cnt[1] < 2; n++) cyc();
        check("b2 windows", OUT'(hs_cnt[1]), OUT'(18));
        check("b2 done pulses", OUT'(done_cnt[1]), OUT'(2));
        check("b2 first window hand", cap_first[1],
              pack9('{201, 202, 203, 206, 207, 208, 211, 212, 213}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
